// File: rtl/data_sram_like_resp.sv
// rtl/data_sram_like_resp.sv - sram-like data-side responder with in-order fixed-latency queue
//
// Purpose: accepts sram-like requests (addr_ok handshake), commits writes and
// samples reads from a word-addressed RAM at accept time, and returns each
// response data_ok/rdata exactly LATENCY cycles after its accept, in order.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   data_sram_req/wr/size  request valid, write flag, size (size is unused)
//   data_sram_wstrb        byte-write enables
//   data_sram_addr/wdata   byte address, write data
//   data_sram_addr_ok      request accepted this cycle (combinational)
//   data_sram_data_ok      registered one-cycle response strobe
//   data_sram_rdata        response data (0 for writes), held between responses
//   stall_i                forces addr_ok low
//   pending                number of outstanding requests
module data_sram_like_resp #(
    parameter int ADDR_W  = 12,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       data_sram_req,
    input  logic                       data_sram_wr,
    input  logic [1:0]                 data_sram_size,
    input  logic [3:0]                 data_sram_wstrb,
    input  logic [31:0]                data_sram_addr,
    input  logic [31:0]                data_sram_wdata,
    output logic                       data_sram_addr_ok,
    output logic                       data_sram_data_ok,
    output logic [31:0]                data_sram_rdata,
    input  logic                       stall_i,
    output logic [$clog2(DEPTH):0]     pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [7:0]       LAT8  = 8'(LATENCY);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    logic [31:0] mem [0:(1 << ADDR_W) - 1];

    logic             q_wr    [DEPTH];
    logic [31:0]      q_rdata [DEPTH];
    logic [7:0]       q_stamp [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [7:0]       stamp_cnt;

    logic              accept;
    logic              pop;
    logic [ADDR_W-1:0] idx;
    logic [7:0]        age;

    // Size and the bits outside the word index carry no information here.
    logic unused_bits;
    assign unused_bits = ^{data_sram_size, data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

    // Full is judged on the registered count; a same-edge pop does not free a slot.
    assign data_sram_addr_ok = !stall_i && (count != FULL);
    assign accept            = data_sram_req && data_sram_addr_ok;
    assign idx               = data_sram_addr[ADDR_W+1:2];
    assign pending           = count;

    // Modulo-256 age of the head entry. Accepts are at most one per cycle and
    // pops keep pace, so the head never ages past LATENCY and the wrap is safe.
    assign age = stamp_cnt - q_stamp[rd_ptr];
    assign pop = (count != '0) && (age >= LAT8);

    // Backing RAM is never cleared; writes are blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (resetn && accept && data_sram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wstrb[i]) begin
                    mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // Queue payload: the read word is captured at accept, so a read sees every
    // write committed on an earlier edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            q_wr[wr_ptr]    <= data_sram_wr;
            q_rdata[wr_ptr] <= data_sram_wr ? 32'h0 : mem[idx];
            q_stamp[wr_ptr] <= stamp_cnt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            stamp_cnt         <= 8'd0;
            data_sram_data_ok <= 1'b0;
            data_sram_rdata   <= 32'h0;
        end else begin
            stamp_cnt <= stamp_cnt + 8'd1;

            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end

            data_sram_data_ok <= pop;
            if (pop) begin
                rd_ptr          <= rd_ptr + PTR_W'(1);
                data_sram_rdata <= q_wr[rd_ptr] ? 32'h0 : q_rdata[rd_ptr];
            end

            case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_like_resp.sv
// tb/tb_data_sram_like_resp.sv - directed self-checking bench for data_sram_like_resp
module tb_data_sram_like_resp;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;

    logic        req = 1'b0, wr = 1'b0, stall = 1'b0;
    logic [3:0]  wstrb = 4'h0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;
    logic [2:0]  pend;

    logic        req8 = 1'b0;
    logic        addr_ok8, data_ok8;
    logic [31:0] rdata8;
    logic [2:0]  pend8;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp6 [300];

    always #5 clk = ~clk;

    data_sram_like_resp dut (
        .clk               (clk),
        .resetn            (resetn),
        .data_sram_req     (req),
        .data_sram_wr      (wr),
        .data_sram_size    (2'b10),
        .data_sram_wstrb   (wstrb),
        .data_sram_addr    (addr),
        .data_sram_wdata   (wdata),
        .data_sram_addr_ok (addr_ok),
        .data_sram_data_ok (data_ok),
        .data_sram_rdata   (rdata),
        .stall_i           (stall),
        .pending           (pend)
    );

    data_sram_like_resp #(.LATENCY(8)) dut8 (
        .clk               (clk),
        .resetn            (resetn),
        .data_sram_req     (req8),
        .data_sram_wr      (1'b0),
        .data_sram_size    (2'b10),
        .data_sram_wstrb   (4'h0),
        .data_sram_addr    (32'h0),
        .data_sram_wdata   (32'h0),
        .data_sram_addr_ok (addr_ok8),
        .data_sram_data_ok (data_ok8),
        .data_sram_rdata   (rdata8),
        .stall_i           (1'b0),
        .pending           (pend8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        req = r; wr = w; addr = a; wdata = d; wstrb = s;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_data_ok", 32'(data_ok), 32'h0);
        chk("rst_pending", 32'(pend), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_addr_ok", 32'(addr_ok), 32'h1);
        tick();
        resetn = 1'b1;

        // 1. Single write then read
        drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        tick();                                   // edge 0
        drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        chk("t1_pending_e0", 32'(pend), 32'h1);
        tick();                                   // edge 1
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("t1_no_ok_e1", 32'(data_ok), 32'h0);
        tick();                                   // edge 2
        chk("t1_wr_ok", 32'(data_ok), 32'h1);
        chk("t1_wr_rdata", rdata, 32'h0);
        tick();                                   // edge 3
        chk("t1_rd_ok", 32'(data_ok), 32'h1);
        chk("t1_rd_rdata", rdata, 32'hDEADBEEF);
        tick();
        chk("t1_ok_low", 32'(data_ok), 32'h0);
        chk("t1_rdata_hold", rdata, 32'hDEADBEEF);
        chk("t1_pending_idle", 32'(pend), 32'h0);

        // 2. Byte strobe
        drive(1'b1, 1'b1, 32'h20, 32'h11223344, 4'hF);
        tick();
        drive(1'b1, 1'b1, 32'h20, 32'h0000AB00, 4'b0010);
        tick();
        drive(1'b1, 1'b0, 32'h23, 32'h0, 4'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("t2_w1_ok", 32'(data_ok), 32'h1);
        tick();
        chk("t2_w2_ok", 32'(data_ok), 32'h1);
        chk("t2_w2_rdata", rdata, 32'h0);
        tick();
        chk("t2_rd_ok", 32'(data_ok), 32'h1);
        chk("t2_rd_rdata", rdata, 32'h1122AB44);
        tick();

        // 3. Full queue on the LATENCY=8 instance
        req8 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("t3_addr_ok_before_e%0d", k), 32'(addr_ok8), 32'((k <= 3) || (k == 9)));
            tick();
            chk($sformatf("t3_pending_e%0d", k), 32'(pend8), (k < 3) ? 32'(k + 1) : ((k < 8) ? 32'd4 : 32'd3));
            chk($sformatf("t3_data_ok_e%0d", k), 32'(data_ok8), 32'(k >= 8));
        end
        req8 = 1'b0;

        // 4. stall_i
        drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        tick();                                   // e0
        drive(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        tick();                                   // e1
        drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        tick();                                   // e2
        chk("t4_ok0", 32'(data_ok), 32'h1);
        chk("t4_rdata0", rdata, 32'hDEADBEEF);
        stall = 1'b1;
        #1;
        chk("t4_addr_ok_stalled", 32'(addr_ok), 32'h0);
        tick();
        chk("t4_ok1", 32'(data_ok), 32'h1);
        chk("t4_rdata1", rdata, 32'h1122AB44);
        tick();
        chk("t4_ok2", 32'(data_ok), 32'h1);
        chk("t4_rdata2", rdata, 32'hDEADBEEF);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("t4_quiet_ok_%0d", k), 32'(data_ok), 32'h0);
            chk($sformatf("t4_quiet_pend_%0d", k), 32'(pend), 32'h0);
        end
        stall = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        // 5. Reset mid-flight
        drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        tick();
        drive(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        tick();
        drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("t5_ok_before", 32'(data_ok), 32'h1);
        chk("t5_pend_before", 32'(pend), 32'h2);
        resetn = 1'b0;
        #1;
        chk("t5_ok_async", 32'(data_ok), 32'h0);
        chk("t5_pend_async", 32'(pend), 32'h0);
        chk("t5_rdata_async", rdata, 32'h0);
        tick();
        resetn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("t5_no_stale_%0d", k), 32'(data_ok), 32'h0);
        end
        drive(1'b1, 1'b0, 32'h23, 32'h0, 4'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        tick();
        chk("t5_ram_kept_ok", 32'(data_ok), 32'h1);
        chk("t5_ram_kept", rdata, 32'h1122AB44);
        tick();

        // 6. Stamp wrap: 300 back-to-back requests, alternating write/read
        for (int i = 0; i < 300; i++) begin
            exp6[i] = (i % 2 == 0) ? 32'h0 : (32'hA5000000 ^ 32'(i - 1));
        end
        for (int k = 0; k < 302; k++) begin
            if (k < 300) begin
                if (k % 2 == 0)
                    drive(1'b1, 1'b1, 32'((k % 16) * 4), 32'hA5000000 ^ 32'(k), 4'hF);
                else
                    drive(1'b1, 1'b0, 32'(((k - 1) % 16) * 4), 32'h0, 4'h0);
            end else begin
                drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            end
            tick();
            if (k < 2) begin
                chk($sformatf("t6_early_%0d", k), 32'(data_ok), 32'h0);
            end else begin
                chk($sformatf("t6_ok_%0d", k - 2), 32'(data_ok), 32'h1);
                chk($sformatf("t6_rdata_%0d", k - 2), rdata, exp6[k - 2]);
            end
        end
        tick();
        chk("t6_drain_ok", 32'(data_ok), 32'h0);
        chk("t6_drain_pend", 32'(pend), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
